ram_rmw_ctrl: RTL and testbench
===============================

Name: ram_rmw_ctrl

Overview:
Command-driven controller that sits directly upstream of the dual-address ram block and owns its write-enable, write-address, read-address and write-data inputs. It accepts single-word commands over a valid/ready handshake. Commands are either a plain write or a read-modify-write that sets, clears or toggles bits in a stored word. Optionally it zero-fills the whole RAM after reset before accepting commands.

Parameters:
AW, 4, address width; matches the ram block's address width; the RAM holds 2**AW words.
DW, 8, data word width; matches the ram block's data width.
RD_LAT, 0, cycles from ram_r_addr_o change to valid ram_data_i; 0 means combinational read.

Ports:
clk_i  in  1  clock; all state on the rising edge
rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  controller can accept a command
cmd_addr_i  in  AW  target address
cmd_op_i  in  2  operation: 00 WRITE, 01 SET, 10 CLEAR, 11 TOGGLE
cmd_data_i  in  DW  write data (WRITE) or bit mask (SET/CLEAR/TOGGLE)
done_o  out  1  one-cycle pulse; the command's write has completed
result_o  out  DW  last word written; held until the next write
init_done_o  out  1  high once the RAM is ready for commands; stays high
ram_write_ena_o  out  1  to ram write enable
ram_w_addr_o  out  AW  to ram write address
ram_r_addr_o  out  AW  to ram read address
ram_data_o  out  DW  to ram write data bus
ram_data_i  in  DW  from ram read data bus

Behaviour:
- Clock and reset are fixed: one clock, clk_i; reset rst_ni is asynchronous and active-low.
- While rst_ni is low, every output is 0; this includes cmd_ready_o, done_o, result_o, init_done_o and ram_write_ena_o.
- Reset takes effect immediately, even mid-command. The in-flight command is discarded and no partial write is issued.
- Reset exit state:
  - INIT when INIT_SWEEP_EN is defined.
  - IDLE otherwise.
- FSM states: INIT, IDLE, READ, WAIT, WRITE, DONE.
- IDLE:
  - cmd_ready_o = 1.
  - A command is accepted on a rising edge where cmd_valid_i and cmd_ready_o are both high. Address, op and data are latched on that edge.
  - If the op is WRITE, go to WRITE. Otherwise go to READ.
- cmd_ready_o is 0 in every state except IDLE. Inputs presented while cmd_ready_o is 0 are ignored.
- READ:
  - ram_r_addr_o = latched address.
  - If RD_LAT = 0, sample ram_data_i at the end of this cycle and go to WRITE.
  - Otherwise go to WAIT.
- WAIT:
  - A down-counter runs for RD_LAT cycles while ram_r_addr_o is held.
  - ram_data_i is sampled on the final WAIT edge; then go to WRITE.
- Modify function on the sampled word w and mask m:
  - SET gives w|m.
  - CLEAR gives w&~m.
  - TOGGLE gives w^m.
  - WRITE gives m directly.
  - The result is always DW bits wide; there is no arithmetic and no carry.
- WRITE:
  - ram_write_ena_o = 1 for exactly one cycle.
  - ram_w_addr_o = latched address.
  - ram_data_o = new word.
  - result_o loads the new word on the closing edge.
- DONE:
  - done_o = 1 for exactly one cycle; then go to IDLE.
- Cycles from accept edge to done_o:
  - WRITE: 2 cycles.
  - Read-modify-write: 3+RD_LAT cycles.
- A new command can be accepted at the earliest on the edge after DONE.
- Because every write completes before the next read starts, there is no read-after-write hazard and no forwarding is needed.
- Output defaults:
  - Outside WRITE, ram_write_ena_o = 0.
  - ram_w_addr_o, ram_r_addr_o and ram_data_o hold their last values.
- Address 2**AW-1 is legal; addresses are never incremented by commands.
- A mask of 0 still performs the full read and write cycle and still pulses done_o.

Optional Feature:
INIT_SWEEP_EN
- Defined:
  - After reset release the controller stays in INIT.
  - It writes 0 to addresses 0 .. 2**AW-1, one per cycle, with ram_write_ena_o = 1.
  - The AW+1-bit sweep counter stops after the last address; it does not wrap.
  - On the cycle after the last write, init_done_o goes to 1 and the state goes to IDLE.
  - done_o is not pulsed during the sweep.
- Undefined:
  - INIT is unreachable.
  - init_done_o = 1 from the first clock edge after reset release.

Decomposition:
- Package ram_rmw_pkg:
  - op_e enum (OP_WRITE, OP_SET, OP_CLEAR, OP_TOGGLE).
  - state_e enum.
  - Default AW/DW constants.
- Sub-module rmw_alu: purely combinational; inputs op, w and m; output is the new word.
- The FSM, the WAIT counter and the sweep counter stay in ram_rmw_ctrl.

Test Plan:
- Reset release with INIT_SWEEP_EN defined, AW=4:
  - 16 consecutive writes of 0 to addresses 0..15.
  - init_done_o rises on the following cycle.
  - Without the macro, init_done_o is 1 on the first edge after reset release.
- WRITE to address 0 with data 8'h6D:
  - Exactly one ram_write_ena_o pulse with address 0 and data 6D.
  - done_o pulses two cycles after the accept edge.
  - result_o = 6D.
- CLEAR sequence on address 0 starting from 6D:
  - Mask 8'h01 writes 6C.
  - Mask 8'h04 then writes 68.
  - Mask 8'h40 then writes 28.
  - Each command has a read on ram_r_addr_o 0 before its write.
- TOGGLE address 15 (starting from 00) with mask FF, RD_LAT=2:
  - Writes FF.
  - done_o arrives 5 cycles after the accept edge.
  - SET with mask 0 then rewrites FF unchanged.
- Backpressure:
  - Hold cmd_valid_i high and change cmd_data_i during a busy period.
  - cmd_ready_o is 0 throughout.
  - Only the data present in the next IDLE cycle is accepted.
- Reset mid-command:
  - Assert rst_ni low during WAIT.
  - Outputs go to 0 immediately, with no write pulse.
  - After release, the stored word is unchanged by the aborted command.

Source files
------------

// File: rtl/ram_rmw_pkg.sv
// rtl/ram_rmw_pkg.sv - shared types and defaults for the ram read-modify-write controller
package ram_rmw_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/ram_rmw_ctrl_alu.sv
// rtl/ram_rmw_ctrl_alu.sv - combinational bit modify unit (write / set / clear / toggle)
import ram_rmw_pkg::*;

module rmw_alu #(
  parameter int DW = DW_DEF
) (
  input  op_e           op_i,
  input  logic [DW-1:0] w_i,
  input  logic [DW-1:0] m_i,
  output logic [DW-1:0] new_o
);

  // Pure bitwise combine of stored word and mask; no carries between bits.
  always_comb begin
    new_o = m_i;
    case (op_i)
      OP_WRITE:  new_o = m_i;
      OP_SET:    new_o = w_i | m_i;
      OP_CLEAR:  new_o = w_i & ~m_i;
      OP_TOGGLE: new_o = w_i ^ m_i;
      default:   new_o = m_i;
    endcase
  end

endmodule

// File: rtl/ram_rmw_ctrl.sv
// rtl/ram_rmw_ctrl.sv - command-driven read-modify-write controller for the dual-address ram; INIT_SWEEP_EN enables post-reset zero fill
import ram_rmw_pkg::*;

module ram_rmw_ctrl #(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [1:0]    cmd_op_i,
  input  logic [DW-1:0] cmd_data_i,
  output logic          done_o,
  output logic [DW-1:0] result_o,
  output logic          init_done_o,
  output logic          ram_write_ena_o,
  output logic [AW-1:0] ram_w_addr_o,
  output logic [AW-1:0] ram_r_addr_o,
  output logic [DW-1:0] ram_data_o,
  input  logic [DW-1:0] ram_data_i
);

  // Counter holds RD_LAT-1 down to 0, so it needs enough bits for RD_LAT-1.
  localparam int CW        = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam bit LAT0      = (RD_LAT == 0);

`ifdef INIT_SWEEP_EN
  localparam state_e RST_ST = ST_INIT;
  localparam logic [AW:0] SWEEP_LAST = {1'b0, {AW{1'b1}}};
  logic [AW:0] sweep_q;
`else
  localparam state_e RST_ST = ST_IDLE;
`endif

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q;
  op_e           op_q;
  logic [DW-1:0] mask_q;
  logic [AW-1:0] w_addr_q, r_addr_q;
  logic [DW-1:0] wdata_q, result_q;
  logic [CW-1:0] cnt_q;
  logic          init_done_q;
  logic [DW-1:0] new_word;
  logic          accept;
  logic          rd_sample;

  rmw_alu #(.DW(DW)) u_alu (
    .op_i  (op_q),
    .w_i   (ram_data_i),
    .m_i   (mask_q),
    .new_o (new_word)
  );

  assign accept    = cmd_valid_i && cmd_ready_o;
  // Read data is valid at the end of READ for combinational RAMs, else at the last WAIT cycle.
  assign rd_sample = (state_q == ST_READ && LAT0) || (state_q == ST_WAIT && cnt_q == '0);

  assign cmd_ready_o     = (state_q == ST_IDLE) && init_done_q;
  assign done_o          = (state_q == ST_DONE);
  assign init_done_o     = init_done_q;
  // INIT is the reset state in sweep builds, so its write strobe is masked while reset is held.
  assign ram_write_ena_o = (state_q == ST_WRITE) || (state_q == ST_INIT && rst_ni);
  assign ram_w_addr_o    = w_addr_q;
  assign ram_r_addr_o    = r_addr_q;
  assign ram_data_o      = wdata_q;
  assign result_o        = result_q;

  // Next-state selection for the command sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef INIT_SWEEP_EN
      ST_INIT:  if (sweep_q == SWEEP_LAST) state_d = ST_IDLE;
`endif
      ST_IDLE:  if (accept) state_d = (op_e'(cmd_op_i) == OP_WRITE) ? ST_WRITE : ST_READ;
      ST_READ:  state_d = LAT0 ? ST_WRITE : ST_WAIT;
      ST_WAIT:  if (cnt_q == '0) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register; reset discards any in-flight command.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RST_ST;
    else         state_q <= state_d;
  end

  // Command latch and RAM-facing address/data registers, which hold between uses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      op_q     <= OP_WRITE;
      mask_q   <= '0;
      w_addr_q <= '0;
      r_addr_q <= '0;
      wdata_q  <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= cmd_addr_i;
        op_q   <= op_e'(cmd_op_i);
        mask_q <= cmd_data_i;
        if (op_e'(cmd_op_i) == OP_WRITE) begin
          w_addr_q <= cmd_addr_i;
          wdata_q  <= cmd_data_i;
        end else begin
          r_addr_q <= cmd_addr_i;
        end
      end
      if (rd_sample) begin
        w_addr_q <= addr_q;
        wdata_q  <= new_word;
      end
      if (state_q == ST_WRITE) result_q <= wdata_q;
`ifdef INIT_SWEEP_EN
      // Sweep data stays at its reset value of zero; only the address advances.
      if (state_q == ST_INIT && sweep_q != SWEEP_LAST) w_addr_q <= sweep_q[AW-1:0] + 1'b1;
`endif
    end
  end

  // Read-latency down-counter, init sweep counter and init-done flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      init_done_q <= 1'b0;
`ifdef INIT_SWEEP_EN
      sweep_q     <= '0;
`endif
    end else begin
      if (state_q == ST_READ)                     cnt_q <= CW'(RD_LAT - 1);
      else if (state_q == ST_WAIT && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
`ifdef INIT_SWEEP_EN
      if (state_q == ST_INIT) begin
        sweep_q <= sweep_q + 1'b1;
        if (sweep_q == SWEEP_LAST) init_done_q <= 1'b1;
      end
`else
      init_done_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_ram_rmw_ctrl.sv
// tb/tb_ram_rmw_ctrl.sv - self-checking bench for ram_rmw_ctrl with a latency-2 RAM model; honours INIT_SWEEP_EN
module tb_ram_rmw_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int RD_LAT = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [1:0]    cmd_op_i = '0;
  logic [DW-1:0] cmd_data_i = '0;
  logic          done_o;
  logic [DW-1:0] result_o;
  logic          init_done_o;
  logic          ram_write_ena_o;
  logic [AW-1:0] ram_w_addr_o;
  logic [AW-1:0] ram_r_addr_o;
  logic [DW-1:0] ram_data_o;
  logic [DW-1:0] ram_data_i;

  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] mem [16] = '{default: 8'h00};
  logic [AW-1:0] rpipe0 = '0;
  logic [AW-1:0] rpipe1 = '0;
  int            wr_total = 0;
  logic [DW-1:0] ref_mem [16] = '{default: 8'h00};

  always #5 clk_i = ~clk_i;

  ram_rmw_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_op_i(cmd_op_i), .cmd_data_i(cmd_data_i),
    .done_o(done_o), .result_o(result_o), .init_done_o(init_done_o),
    .ram_write_ena_o(ram_write_ena_o), .ram_w_addr_o(ram_w_addr_o),
    .ram_r_addr_o(ram_r_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  // RAM model: synchronous write, read data valid two cycles after the read address.
  always @(posedge clk_i) begin
    if (ram_write_ena_o) begin
      mem[ram_w_addr_o] <= ram_data_o;
      wr_total <= wr_total + 1;
    end
    rpipe0 <= ram_r_addr_o;
    rpipe1 <= rpipe0;
  end
  assign ram_data_i = mem[rpipe1];

  function automatic logic [7:0] model_op(input logic [1:0] op, input logic [7:0] w, input logic [7:0] m);
    case (op)
      2'd0: return m;
      2'd1: return w | m;
      2'd2: return w & ~m;
      default: return w ^ m;
    endcase
  endfunction

  // Called at a negedge right after reset release; checks the init behaviour.
  task automatic check_init();
`ifdef INIT_SWEEP_EN
    int bad;
    bad = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    #1;
    for (int k = 0; k < 16; k++) begin
      if (ram_write_ena_o !== 1'b1 || ram_w_addr_o !== 4'(k) || ram_data_o !== 8'h00 || init_done_o !== 1'b0 || done_o !== 1'b0) bad++;
      @(negedge clk_i);
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL init_sweep: %0d bad sweep cycles, required 0", bad); end
    n_checks++;
    if (init_done_o !== 1'b1 || ram_write_ena_o !== 1'b0) begin
      n_fail++; $display("FAIL init_done_after_sweep: init_done=%b wena=%b, required 1 0", init_done_o, ram_write_ena_o);
    end
`else
    #1;
    n_checks++;
    if (init_done_o !== 1'b0) begin n_fail++; $display("FAIL init_done_at_release: got %b required 0", init_done_o); end
    @(negedge clk_i);
    n_checks++;
    if (init_done_o !== 1'b1 || cmd_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL init_done_first_edge: init_done=%b ready=%b, required 1 1", init_done_o, cmd_ready_o);
    end
`endif
  endtask

  // Issues one command at a negedge in IDLE and follows it to done; ends at the next IDLE negedge.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] a, input logic [7:0] m,
                        output logic [7:0] wd_obs, output int lat_obs);
    int n, wr, lat_exp;
    logic [3:0] wa;
    logic rd_ok;
    logic [7:0] exp;
    n = 0;
    while (cmd_ready_o !== 1'b1 && n < 20) begin @(negedge clk_i); n++; end
    n_checks++;
    if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL ready_timeout: ready=%b required 1", cmd_ready_o); end
    exp = model_op(op, ref_mem[a], m);
    lat_exp = (op == 2'd0) ? 2 : 3 + RD_LAT;
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_addr_i = a; cmd_data_i = m;
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    n = 1; wr = 0; wa = '0; wd_obs = '0; rd_ok = 1'b0;
    while (n < 20) begin
      if (op != 2'd0 && wr == 0 && ram_r_addr_o === a) rd_ok = 1'b1;
      if (ram_write_ena_o === 1'b1) begin wr++; wa = ram_w_addr_o; wd_obs = ram_data_o; end
      if (done_o === 1'b1) break;
      @(negedge clk_i);
      n++;
    end
    lat_obs = n;
    n_checks++;
    if (n !== lat_exp) begin n_fail++; $display("FAIL latency op%0d: got %0d required %0d", op, n, lat_exp); end
    n_checks++;
    if (wr !== 1 || wa !== a || wd_obs !== exp) begin
      n_fail++; $display("FAIL write op%0d a%0d: pulses %0d addr %h data %h, required 1 %h %h", op, a, wr, wa, wd_obs, a, exp);
    end
    n_checks++;
    if (result_o !== exp) begin n_fail++; $display("FAIL result op%0d: got %h required %h", op, result_o, exp); end
    if (op != 2'd0) begin
      n_checks++;
      if (rd_ok !== 1'b1) begin n_fail++; $display("FAIL read_before_write a%0d: seen %b required 1", a, rd_ok); end
    end
    ref_mem[a] = exp;
    @(negedge clk_i);
    n_checks++;
    if (done_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL after_done: done=%b ready=%b, required 0 1", done_o, cmd_ready_o);
    end
  endtask

  task automatic test_reset();
    cmd_valid_i = 1'b1; cmd_data_i = 8'hA5;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if ({cmd_ready_o, done_o, result_o, init_done_o, ram_write_ena_o, ram_w_addr_o, ram_r_addr_o, ram_data_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: ready=%b done=%b res=%h init=%b wena=%b", cmd_ready_o, done_o, result_o, init_done_o, ram_write_ena_o);
    end
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    check_init();
  endtask

  task automatic test_write();
    logic [7:0] wd; int lat;
    do_cmd(2'd0, 4'd0, 8'h6D, wd, lat);
    n_checks++;
    if (wd !== 8'h6D || lat !== 2) begin n_fail++; $display("FAIL write_6d: data %h lat %0d, required 6d 2", wd, lat); end
  endtask

  task automatic test_clear_seq();
    logic [7:0] masks [3] = '{8'h01, 8'h04, 8'h40};
    logic [7:0] want  [3] = '{8'h6C, 8'h68, 8'h28};
    logic [7:0] wd; int lat;
    for (int i = 0; i < 3; i++) begin
      do_cmd(2'd2, 4'd0, masks[i], wd, lat);
      n_checks++;
      if (wd !== want[i]) begin n_fail++; $display("FAIL clear_seq%0d: got %h required %h", i, wd, want[i]); end
    end
  endtask

  task automatic test_toggle_top();
    logic [7:0] wd; int lat;
    do_cmd(2'd3, 4'd15, 8'hFF, wd, lat);
    n_checks++;
    if (wd !== 8'hFF || lat !== 5) begin n_fail++; $display("FAIL toggle_top: data %h lat %0d, required ff 5", wd, lat); end
    do_cmd(2'd1, 4'd15, 8'h00, wd, lat);
    n_checks++;
    if (wd !== 8'hFF || lat !== 5) begin n_fail++; $display("FAIL set_mask0: data %h lat %0d, required ff 5", wd, lat); end
  endtask

  task automatic test_random();
    logic [7:0] wd; int lat;
    for (int i = 0; i < 24; i++)
      do_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'($urandom), wd, lat);
  endtask

  task automatic test_back_to_back();
    int n, bad;
    logic [7:0] wd; int lat;
    cmd_valid_i = 1'b1; cmd_op_i = 2'd0; cmd_addr_i = 4'd7; cmd_data_i = 8'h3C;
    @(posedge clk_i);
    ref_mem[7] = 8'h3C;
    n = 0; bad = 0;
    do begin
      @(negedge clk_i);
      n++;
      if (cmd_ready_o !== 1'b0) bad++;
      cmd_data_i = 8'($urandom); cmd_op_i = 2'($urandom_range(0, 3));
    end while (done_o !== 1'b1 && n < 20);
    n_checks++;
    if (bad !== 0 || done_o !== 1'b1) begin
      n_fail++; $display("FAIL backpressure_ready: %0d ready-high busy cycles, done=%b, required 0 1", bad, done_o);
    end
    @(negedge clk_i);
    do_cmd(2'd1, 4'd7, 8'h81, wd, lat);
    n_checks++;
    if (wd !== 8'hBD) begin n_fail++; $display("FAIL backpressure_data: got %h required bd", wd); end
  endtask

  task automatic test_reset_mid();
    int wr_before;
    logic [7:0] wd; int lat;
    logic [7:0] keep;
    keep = ref_mem[5];
    cmd_valid_i = 1'b1; cmd_op_i = 2'd3; cmd_addr_i = 4'd5; cmd_data_i = 8'hFF;
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    wr_before = wr_total;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready_o, done_o, result_o, init_done_o, ram_write_ena_o, ram_w_addr_o, ram_r_addr_o, ram_data_o} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: ready=%b done=%b res=%h init=%b wena=%b", cmd_ready_o, done_o, result_o, init_done_o, ram_write_ena_o);
    end
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (wr_total !== wr_before) begin n_fail++; $display("FAIL midreset_write: got %0d writes required 0", wr_total - wr_before); end
    rst_ni = 1'b1;
    check_init();
`ifndef INIT_SWEEP_EN
    n_checks++;
    if (ref_mem[5] !== keep) begin n_fail++; $display("FAIL midreset_refstate: got %h required %h", ref_mem[5], keep); end
`endif
    do_cmd(2'd1, 4'd5, 8'h00, wd, lat);
  endtask

  initial begin
    test_reset();
    test_write();
    test_clear_seq();
    test_toggle_top();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
